// File: rtl/mem_if_pkg.sv
// Shared constants, payload types and FSM encoding for the cacheline-to-burst adapter.
package mem_if_pkg;

  localparam int unsigned LINE_WIDTH   = 256;
  localparam int unsigned BURST_WIDTH  = 64;
  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned BEATS        = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned CNT_WIDTH    = $clog2(BEATS);
  localparam int unsigned OFFSET_WIDTH = $clog2(LINE_WIDTH / 8);

  typedef logic [BURST_WIDTH-1:0]            beat_t;
  typedef logic [BEATS-1:0][BURST_WIDTH-1:0] line_t;
  typedef logic [ADDR_WIDTH-1:0]             addr_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } lba_state_e;

endpackage

// File: rtl/line_burst_adapter.sv
// Splits one cacheline read/write from the arbiter into a BEATS-long memory burst
// and returns a single line-wide completion pulse.
module line_burst_adapter
  import mem_if_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam addr_t ADDR_MASK = ~ADDR_WIDTH'((1 << OFFSET_WIDTH) - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);

  lba_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  line_t                buf_q, buf_d;
  line_t                line_q, line_d;
  addr_t                addr_q, addr_d;
  beat_t                burst_q, burst_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic                 resp_q, resp_d;

  // State and all outputs are registered together so each output tracks the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
    end
  end

  // Next-state and next-output logic; request strobes are recomputed every cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    line_d  = line_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    resp_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (read_i) begin
          addr_d  = address_i & ADDR_MASK;
          cnt_d   = '0;
          rd_d    = 1'b1;
          state_d = RD_BURST;
        end else if (write_i) begin
          addr_d  = address_i & ADDR_MASK;
          cnt_d   = '0;
          buf_d   = line_t'(line_i);
          burst_d = line_i[BURST_WIDTH-1:0];
          wr_d    = 1'b1;
          state_d = WR_BURST;
        end
      end

      RD_BURST: begin
        rd_d = 1'b1;
        if (resp_i) begin
          buf_d[cnt_q] = burst_i;
          cnt_d        = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == LAST_BEAT) begin
            line_d  = buf_d;
            rd_d    = 1'b0;
            resp_d  = 1'b1;
            state_d = RD_DONE;
          end
        end
      end

      WR_BURST: begin
        wr_d = 1'b1;
        if (resp_i) begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          burst_d = buf_q[cnt_d];
          if (cnt_q == LAST_BEAT) begin
            wr_d    = 1'b0;
            resp_d  = 1'b1;
            state_d = WR_DONE;
          end
        end
      end

      RD_DONE,
      WR_DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign burst_o   = burst_q;
  assign read_o    = rd_q;
  assign write_o   = wr_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Scoreboard bench for line_burst_adapter: bench acts as arbiter and memory.
module tb_line_burst_adapter;
  import mem_if_pkg::*;

  logic                   clk;
  logic                   rst;
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  line_burst_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    n_checks = 0;
  int    n_errors = 0;
  line_t sb_line[$];
  beat_t sb_beat[$];
  line_t last_line = '0;

  task automatic chk(input string tag, input logic [LINE_WIDTH-1:0] act,
                     input logic [LINE_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Idle cycles with no request; optional spurious memory acknowledge.
  task automatic idle(input int n, input bit spur);
    repeat (n) begin
      @(negedge clk);
      read_i  = 1'b0;
      write_i = 1'b0;
      resp_i  = spur;
      chk("idle_resp_o", resp_o, 0);
      chk("idle_read_o", read_o, 0);
      chk("idle_write_o", write_o, 0);
    end
  endtask

  // Issue one line request, play the memory side, and check against the scoreboard.
  task automatic do_txn(input bit rd, input bit wr, input addr_t addr, input line_t data,
                        input int gap, input bit spur_done, input int abort_at);
    bit    is_rd = rd;
    addr_t ea = addr & ~32'h1F;
    int    beat = 0;
    int    idle_cnt = gap;
    int    cyc = 0;
    bit    done = 1'b0;
    line_t exp_line;
    beat_t exp_beat;
    @(negedge clk);
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    line_i    = data;
    resp_i    = 1'b0;
    if (is_rd) begin
      sb_line.push_back(data);
      last_line = data;
    end else begin
      sb_line.push_back(last_line);
      for (int k = 0; k < BEATS; k++) sb_beat.push_back(data[k]);
    end
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (abort_at >= 0 && beat == abort_at) begin
        rst    = 1'b1;
        resp_i = 1'b0;
        @(negedge clk);
        chk("abort_read_o", read_o, 0);
        chk("abort_resp_o", resp_o, 0);
        chk("abort_line_o", line_o, 0);
        rst       = 1'b0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        exp_line  = sb_line.pop_front();
        last_line = '0;
        return;
      end
      if (resp_o) begin
        done = 1'b1;
        exp_line = sb_line.size() > 0 ? sb_line.pop_front() : 'x;
        chk("latency", cyc, 5 + 3 * gap);
        chk("line_o", line_o, exp_line);
        chk("done_read_o", read_o, 0);
        chk("done_write_o", write_o, 0);
        resp_i = spur_done;
      end else begin
        chk("busy_read_o", read_o, is_rd);
        chk("busy_write_o", write_o, !is_rd);
        chk("address_o", address_o, ea);
        if (beat < BEATS && idle_cnt >= gap) begin
          resp_i  = 1'b1;
          burst_i = is_rd ? data[beat] : {$urandom, $urandom};
          if (!is_rd) begin
            exp_beat = sb_beat.size() > 0 ? sb_beat.pop_front() : 'x;
            chk("burst_o", burst_o, exp_beat);
          end
          beat++;
          idle_cnt = 0;
        end else begin
          resp_i  = 1'b0;
          burst_i = {$urandom, $urandom};
          idle_cnt++;
        end
      end
    end
    if (!done) begin
      chk("resp_timeout", 0, 1);
      exp_line = sb_line.pop_front();
    end
  endtask

  function automatic line_t fill(input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] c, input logic [3:0] d);
    line_t l;
    l[0] = {16{a}};
    l[1] = {16{b}};
    l[2] = {16{c}};
    l[3] = {16{d}};
    return l;
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int k = 0; k < BEATS; k++) l[k] = {$urandom, $urandom};
    return l;
  endfunction

  initial begin
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_resp_o", resp_o, 0);
    chk("rst_address_o", address_o, 0);
    chk("rst_burst_o", burst_o, 0);
    chk("rst_line_o", line_o, 0);
    rst = 1'b0;
    idle(1, 1'b0);

    do_txn(1'b1, 1'b0, 32'h0000_1234, fill(4'h1, 4'h2, 4'h3, 4'h4), 0, 1'b0, -1);
    chk("rd1_address_o", address_o, 32'h0000_1220);
    idle(1, 1'b0);
    do_txn(1'b0, 1'b1, 32'h8000_0047, fill(4'hA, 4'hB, 4'hC, 4'hD), 2, 1'b0, -1);
    idle(1, 1'b0);
    do_txn(1'b1, 1'b1, 32'h0000_5678, rand_line(), 1, 1'b0, -1);
    idle(3, 1'b1);
    do_txn(1'b1, 1'b0, 32'h1234_5660, rand_line(), 0, 1'b1, -1);
    idle(2, 1'b0);
    do_txn(1'b1, 1'b0, 32'h0000_9000, rand_line(), 0, 1'b0, 2);
    idle(1, 1'b0);
    do_txn(1'b1, 1'b0, 32'h0000_9000, rand_line(), 0, 1'b0, -1);
    do_txn(1'b1, 1'b0, 32'h0000_A020, rand_line(), 0, 1'b0, -1);
    idle(1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, rand_line(),
             int'($urandom_range(0, 2)), 1'b0, -1);
      idle(1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
